connection_table_scanner: RTL and testbench
===========================================

// Module: connection_table_scanner
// PURPOSE
// Read-side companion of connection_table. On start, walks every node_B entry for one
// node_A row, performs single-cycle-latency reads through the table's read port, and
// streams each nonzero entry (neighbour id, weight) on a valid/ready output. Feeds
// routing/graph logic that needs a node's adjacency list; zero means "no connection".
// PARAMETERS
// DATA_WIDTH         6  width of one table entry (edge weight)
// NODE_ADDRESS_SIZE  4  node id width; row length = 1<<NODE_ADDRESS_SIZE
// SKIP_SELF          1  1: never read or emit entry (node_A,node_A)
// PORTS
// CLK              in   1                     clock, all logic on rising edge
// RST              in   1                     synchronous reset, active-high
// start            in   1                     begin scan of row node_A_in (IDLE only)
// node_A_in        in   NODE_ADDRESS_SIZE     row to scan, latched on accepted start
// busy             out  1                     1 from cycle after start until DONE exits
// mem_node_A       out  NODE_ADDRESS_SIZE     table row address (latched node_A)
// mem_node_B       out  NODE_ADDRESS_SIZE     table column address (scan index)
// mem_chip_select  out  1                     1 only in ISSUE state (non-skipped)
// mem_write_enable out  1                     constant 0
// mem_OUT          in   DATA_WIDTH            table read data, valid 1 cycle after ISSUE
// out_valid        out  1                     output beat valid
// out_ready        in   1                     consumer accepts beat
// out_node         out  NODE_ADDRESS_SIZE     neighbour id (node_B of entry)
// out_weight       out  DATA_WIDTH            entry value, never 0 when out_valid
// done             out  1                     one-cycle pulse, scan finished
// neighbor_count   out  NODE_ADDRESS_SIZE+1   beats emitted in last/current scan
// BEHAVIOUR
// - Reset: state=IDLE; busy, out_valid, done, mem_chip_select, neighbor_count,
//   out_node, out_weight, mem_node_A, mem_node_B all 0. RST mid-scan aborts, no done.
// - FSM IDLE/ISSUE/CAPTURE/EMIT/DONE; index b counts 0..(1<<NODE_ADDRESS_SIZE)-1.
// - IDLE: start=1 -> latch node_A_in, b=0, neighbor_count=0, go ISSUE. start ignored
//   in every other state.
// - ISSUE: mem_node_B=b. If SKIP_SELF && b==node_A: chip_select=0, advance (below).
//   Else chip_select=1 -> CAPTURE.
// - CAPTURE: mem_OUT valid this cycle. Nonzero: register out_node=b, out_weight=mem_OUT,
//   neighbor_count+1, -> EMIT. Zero: advance.
// - EMIT: out_valid=1; out_node/out_weight held stable until out_valid&&out_ready,
//   then out_valid=0 next cycle and advance. out_ready while not valid: no effect.
// - advance: b==max -> DONE; else b+1 -> ISSUE. No wrap-around; b never exceeds max.
// - DONE: done=1 one cycle, busy=0 next -> IDLE. neighbor_count held until next start.
// - Timing: 2 cycles/entry read + 1 cycle skipped self + >=1 cycle per EMIT beat.
//   Empty row, N=4, SKIP_SELF=1: start edge t0 -> done high in cycle t0+32.
// - Max neighbour count 1<<NODE_ADDRESS_SIZE fits neighbor_count width (SKIP_SELF=0).
// TESTING (bench instantiates connection_table on the mem_* port, writes via test port)
// 1 Empty table, start node_A_in=3, out_ready=1 -> no out_valid, done at t0+32, count=0.
// 2 Write (5,2)=42,(5,9)=7,(5,15)=63; start A=5 -> beats (2,42),(9,7),(15,63) in order,
//   done once, neighbor_count=3.
// 3 As 2, out_ready=0 for 5 cycles on first beat -> out_valid held, (2,42) stable,
//   no beat lost or duplicated; remaining beats follow.
// 4 Write (5,5)=11, SKIP_SELF=1 -> no beat for node 5, mem_chip_select never 1 with
//   mem_node_B=5; SKIP_SELF=0 -> beat (5,11) emitted, count includes it.
// 5 RST=1 during EMIT of (9,7) -> next cycle IDLE, out_valid=0, busy=0, no done;
//   new start A=5 re-emits from (2,42).
// 6 start pulsed with A=7 while busy scanning A=5 -> ignored; only row 5 beats emitted.

Source files
------------

// File: rtl/connection_table_scanner.sv
// Walks one row of a connection table through its single-cycle read port and
// streams every nonzero entry as (neighbour id, weight) on a valid/ready output.
module connection_table_scanner #(
  parameter int DATA_WIDTH        = 6,
  parameter int NODE_ADDRESS_SIZE = 4,
  parameter bit SKIP_SELF         = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic [NODE_ADDRESS_SIZE-1:0] node_A_in,
  output logic                         busy,
  output logic [NODE_ADDRESS_SIZE-1:0] mem_node_A,
  output logic [NODE_ADDRESS_SIZE-1:0] mem_node_B,
  output logic                         mem_chip_select,
  output logic                         mem_write_enable,
  input  logic [DATA_WIDTH-1:0]        mem_OUT,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NODE_ADDRESS_SIZE-1:0] out_node,
  output logic [DATA_WIDTH-1:0]        out_weight,
  output logic                         done,
  output logic [NODE_ADDRESS_SIZE:0]   neighbor_count
);

  localparam logic [NODE_ADDRESS_SIZE-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, EMIT, DONE} state_t;

  state_t                         state;
  state_t                         state_next;
  logic [NODE_ADDRESS_SIZE-1:0]   node_a;
  logic [NODE_ADDRESS_SIZE-1:0]   idx;
  logic [NODE_ADDRESS_SIZE-1:0]   node_reg;
  logic [DATA_WIDTH-1:0]          weight_reg;
  logic [NODE_ADDRESS_SIZE:0]     count;
  logic                           self_hit;
  logic                           last_idx;
  logic                           step;
  logic                           hit;

  assign self_hit = SKIP_SELF && (idx == node_a);
  assign last_idx = (idx == LAST_IDX);
  assign hit      = (mem_OUT != '0);

  // step means "this entry is finished"; the index never wraps past the last column
  always_comb begin
    state_next = state;
    step       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (self_hit) step = 1'b1;
               else          state_next = CAPTURE;
      CAPTURE: if (hit) state_next = EMIT;
               else     step = 1'b1;
      EMIT:    if (out_ready) step = 1'b1;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (step) state_next = last_idx ? DONE : ISSUE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      node_a     <= '0;
      idx        <= '0;
      node_reg   <= '0;
      weight_reg <= '0;
      count      <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        node_a <= node_A_in;
        idx    <= '0;
        count  <= '0;
      end
      if (state == CAPTURE && hit) begin
        node_reg   <= idx;
        weight_reg <= mem_OUT;
        count      <= count + 1'b1;
      end
      if (step && !last_idx) idx <= idx + 1'b1;
    end
  end

  assign busy             = (state != IDLE);
  assign mem_node_A       = node_a;
  assign mem_node_B       = idx;
  assign mem_chip_select  = (state == ISSUE) && !self_hit;
  assign mem_write_enable = 1'b0;
  assign out_valid        = (state == EMIT);
  assign out_node         = node_reg;
  assign out_weight       = weight_reg;
  assign done             = (state == DONE);
  assign neighbor_count   = count;

endmodule

// File: tb/tb_connection_table_scanner.sv
// Bench for connection_table_scanner: two instances (self-skip on/off) share one
// table model; beats, counts and done latency are compared against a row-walk model.
module tb_connection_table_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] node_a_in;
  logic       out_ready;

  logic       busy1, cs1, we1, ov1, done1;
  logic [3:0] mna1, mnb1, on1;
  logic [5:0] mo1, ow1;
  logic [4:0] cnt1;
  logic       busy0, cs0, we0, ov0, done0;
  logic [3:0] mna0, mnb0, on0;
  logic [5:0] mo0, ow0;
  logic [4:0] cnt0;

  logic [5:0] tbl [16][16];

  int checks = 0;
  int failures = 0;
  int got1[$], got0[$], exp1[$], exp0[$];
  int dcnt1, dcnt0, self_cs1, stab_err, zero_err;
  logic hold1 = 0, hold0 = 0;
  logic [3:0] hn1, hn0;
  logic [5:0] hw1, hw0;

  always #5 clk = ~clk;

  connection_table_scanner #(.DATA_WIDTH(6), .NODE_ADDRESS_SIZE(4), .SKIP_SELF(1'b1)) dut1 (
    .CLK(clk), .RST(rst), .start(start), .node_A_in(node_a_in), .busy(busy1),
    .mem_node_A(mna1), .mem_node_B(mnb1), .mem_chip_select(cs1), .mem_write_enable(we1),
    .mem_OUT(mo1), .out_valid(ov1), .out_ready(out_ready), .out_node(on1),
    .out_weight(ow1), .done(done1), .neighbor_count(cnt1));

  connection_table_scanner #(.DATA_WIDTH(6), .NODE_ADDRESS_SIZE(4), .SKIP_SELF(1'b0)) dut0 (
    .CLK(clk), .RST(rst), .start(start), .node_A_in(node_a_in), .busy(busy0),
    .mem_node_A(mna0), .mem_node_B(mnb0), .mem_chip_select(cs0), .mem_write_enable(we0),
    .mem_OUT(mo0), .out_valid(ov0), .out_ready(out_ready), .out_node(on0),
    .out_weight(ow0), .done(done0), .neighbor_count(cnt0));

  // table read port: data appears the cycle after chip select
  always @(posedge clk) begin
    if (cs1 && !we1) mo1 <= tbl[mna1][mnb1];
    if (cs0 && !we0) mo0 <= tbl[mna0][mnb0];
  end

  always @(negedge clk) begin
    if (rst) begin
      hold1 = 0;
      hold0 = 0;
    end else begin
      if (ov1 && out_ready) got1.push_back(int'(on1) * 64 + int'(ow1));
      if (ov0 && out_ready) got0.push_back(int'(on0) * 64 + int'(ow0));
      if ((ov1 && ow1 == 0) || (ov0 && ow0 == 0)) zero_err++;
      if (done1) dcnt1++;
      if (done0) dcnt0++;
      if (cs1 && mnb1 == mna1) self_cs1++;
      if (hold1 && !(ov1 && on1 == hn1 && ow1 == hw1)) stab_err++;
      if (hold0 && !(ov0 && on0 == hn0 && ow0 == hw0)) stab_err++;
      hold1 = ov1 && !out_ready; hn1 = on1; hw1 = ow1;
      hold0 = ov0 && !out_ready; hn0 = on0; hw0 = ow0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void build_exp(input int a);
    exp1.delete();
    exp0.delete();
    for (int b = 0; b < 16; b++)
      if (tbl[a][b] != 0) begin
        exp0.push_back(b * 64 + int'(tbl[a][b]));
        if (b != a) exp1.push_back(b * 64 + int'(tbl[a][b]));
      end
  endfunction

  // cycles from the start edge to the edge after which done is visible, with out_ready=1
  function automatic int lat_model(input int a, input bit skip);
    int n = 1;
    for (int b = 0; b < 16; b++)
      if (skip && b == a) n += 1;
      else n += 2 + ((tbl[a][b] != 0) ? 1 : 0);
    return n;
  endfunction

  // mode 0: always ready, 1: random ready, 2: first beat stalled 5 valid cycles
  task automatic run_scan(input string tag, input int a, input int mode,
                          input int pulse_at, input int pulse_a);
    int n = 0, lat1 = 0, lat0 = 0, held = 0;
    got1.delete(); got0.delete();
    dcnt1 = 0; dcnt0 = 0; self_cs1 = 0; stab_err = 0; zero_err = 0;
    build_exp(a);
    node_a_in = 4'(a);
    start = 1'b1;
    while ((lat1 == 0 || lat0 == 0) && n < 3000) begin
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom % 3) != 0;
      else begin
        if (ov1 && got1.size() == 0) held++;
        out_ready = (held > 5) || (got1.size() > 0);
      end
      @(posedge clk); n++; #1;
      start = (n == pulse_at);
      node_a_in = (n == pulse_at) ? 4'(pulse_a) : 4'(a);
      if (done1 && lat1 == 0) lat1 = n;
      if (done0 && lat0 == 0) lat0 = n;
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_timeout"}, int'(n < 3000), 1);
    chk({tag, "_cnt1"}, int'(cnt1), exp1.size());
    chk({tag, "_cnt0"}, int'(cnt0), exp0.size());
    chk({tag, "_done1_once"}, dcnt1, 1);
    chk({tag, "_done0_once"}, dcnt0, 1);
    chk({tag, "_self_cs"}, self_cs1, 0);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_nonzero"}, zero_err, 0);
    chk({tag, "_idle"}, int'(busy1 | busy0 | ov1 | ov0), 0);
    chk({tag, "_beats1_n"}, got1.size(), exp1.size());
    chk({tag, "_beats0_n"}, got0.size(), exp0.size());
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      chk({tag, "_beat1"}, got1[i], exp1[i]);
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      chk({tag, "_beat0"}, got0[i], exp0[i]);
    if (mode == 0) begin
      chk({tag, "_lat1"}, lat1, lat_model(a, 1'b1));
      chk({tag, "_lat0"}, lat0, lat_model(a, 1'b0));
    end
  endtask

  task automatic reset_mid_emit();
    int n = 0;
    dcnt1 = 0;
    node_a_in = 4'd5; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(ov1 && on1 == 4'd9) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("rst_reach_emit", int'(n < 200), 1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_emit_held", int'(ov1), 1);
    chk("rst_emit_weight", int'(ow1), 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst_out_valid", int'(ov1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_count", int'(cnt1), 0);
    chk("rst_out_regs", int'(on1) + int'(ow1) + int'(mna1) + int'(mnb1), 0);
    chk("rst_cs", int'(cs1), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_still_idle", int'(busy1), 0);
    chk("rst_no_done", dcnt1, 0);
  endtask

  typedef struct {
    int a; int mode; int pulse_at; int pulse_a; bit self_entry; int exp_cnt1; int exp_cnt0; int exp_lat1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{3, 0, 0, 0, 1'b0, 0, 0, 32};
    vecs[1] = '{5, 0, 0, 0, 1'b0, 3, 3, 35};
    vecs[2] = '{5, 2, 0, 0, 1'b0, 3, 3, -1};
    vecs[3] = '{5, 0, 4, 7, 1'b0, 3, 3, 35};
    vecs[4] = '{5, 0, 0, 0, 1'b1, 3, 4, 35};

    rst = 1'b1; start = 1'b0; node_a_in = '0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) tbl[i][j] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'(busy1) + int'(ov1) + int'(done1) + int'(cs1) + int'(we1), 0);
    chk("reset_regs", int'(cnt1) + int'(on1) + int'(ow1) + int'(mna1) + int'(mnb1), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    tbl[5][2] = 6'd42; tbl[5][9] = 6'd7; tbl[5][15] = 6'd63;
    foreach (vecs[k]) begin
      tbl[5][5] = vecs[k].self_entry ? 6'd11 : 6'd0;
      run_scan($sformatf("vec%0d", k), vecs[k].a, vecs[k].mode, vecs[k].pulse_at, vecs[k].pulse_a);
      chk($sformatf("vec%0d_tcnt1", k), int'(cnt1), vecs[k].exp_cnt1);
      chk($sformatf("vec%0d_tcnt0", k), int'(cnt0), vecs[k].exp_cnt0);
      if (vecs[k].exp_lat1 >= 0)
        chk($sformatf("vec%0d_tlat1", k), lat_model(vecs[k].a, 1'b1), vecs[k].exp_lat1);
      chk($sformatf("vec%0d_row_latched", k), int'(mna1), vecs[k].a);
    end

    tbl[5][5] = 6'd0;
    reset_mid_emit();
    run_scan("after_rst", 5, 0, 0, 0);
    chk("after_rst_first", (got1.size() > 0) ? got1[0] : -1, 2 * 64 + 42);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          tbl[i][j] = (($urandom % 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      if (r == 19)
        for (int j = 0; j < 16; j++) tbl[8][j] = 6'($urandom_range(1, 63));
      run_scan($sformatf("rnd%0d", r), (r == 19) ? 8 : int'($urandom % 16), r % 2, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
